// File: rtl/dispatch_select_queue_if.sv
// Dispatch/Select/slot-return bundle for dispatch_select_queue.
// The queue connects through the slave modport; the producer/consumer side uses master.
interface dispatch_select_queue_if #(
    parameter int DISP_WIDTH = 2,
    parameter int SEL_WIDTH  = 2,
    parameter int UOP_W      = 64,
    parameter int NUM_SLOTS  = 16,
    parameter int DEPTH      = 8
);
    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int FS_W  = $clog2(NUM_SLOTS + 1);

    logic                          flush;
    logic [DISP_WIDTH-1:0]         disp_valid;
    logic [DISP_WIDTH*UOP_W-1:0]   disp_uop;
    logic                          disp_ready;
    logic [SEL_WIDTH-1:0]          sel_valid;
    logic [SEL_WIDTH*UOP_W-1:0]    sel_uop;
    logic [SEL_WIDTH*IDX_W-1:0]    sel_idx;
    logic [SEL_WIDTH-1:0]          sel_ready;
    logic [SEL_WIDTH-1:0]          free_valid;
    logic [SEL_WIDTH*IDX_W-1:0]    free_idx;
    logic [CNT_W-1:0]              count;
    logic [FS_W-1:0]               free_slots;

    modport master (
        output flush, disp_valid, disp_uop, sel_ready, free_valid, free_idx,
        input  disp_ready, sel_valid, sel_uop, sel_idx, count, free_slots
    );

    modport slave (
        input  flush, disp_valid, disp_uop, sel_ready, free_valid, free_idx,
        output disp_ready, sel_valid, sel_uop, sel_idx, count, free_slots
    );
endinterface

// File: rtl/dispatch_select_queue.sv
// Multi-lane in-order queue between Dispatch and Select with payload-slot allocation.
// Define DSQ_BYPASS_EN to let an empty queue forward dispatch lanes to Select in the same cycle.
module dispatch_select_queue #(
    parameter int DISP_WIDTH = 2,
    parameter int SEL_WIDTH  = 2,
    parameter int DEPTH      = 8,
    parameter int UOP_W      = 64,
    parameter int NUM_SLOTS  = 16
) (
    input  logic clk,
    input  logic rst_n,
    dispatch_select_queue_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int FS_W  = $clog2(NUM_SLOTS + 1);

    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_SLOTS-1:0] slot_free_q, slot_free_d;
    logic [UOP_W-1:0]     uop_mem_q [DEPTH];
    logic [IDX_W-1:0]     idx_mem_q [DEPTH];

    logic [FS_W-1:0]       free_cnt;
    logic                  disp_ready;
    logic                  bypass_on;
    logic [DISP_WIDTH-1:0] accept;
    logic [IDX_W-1:0]      alloc_idx [DISP_WIDTH];
    logic [PTR_W-1:0]      wr_addr   [DISP_WIDTH];
    logic [SEL_WIDTH-1:0]  sel_valid;
    logic [CNT_W-1:0]      enq_cnt, pop_cnt, skip_cnt;

    always_comb begin
        free_cnt = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            free_cnt = free_cnt + FS_W'(slot_free_q[s]);
        end
    end

    assign disp_ready = (count_q <= CNT_W'(DEPTH - DISP_WIDTH)) &&
                        (free_cnt >= FS_W'(DISP_WIDTH)) && !bus.flush;

    // Lane i takes the i-th lowest free slot; only the valid prefix is accepted.
    always_comb begin
        logic [NUM_SLOTS-1:0] avail;
        logic run;
        logic found;
        avail   = slot_free_q;
        run     = disp_ready;
        enq_cnt = '0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
            run          = run & bus.disp_valid[i];
            accept[i]    = run;
            enq_cnt      = enq_cnt + CNT_W'(run);
            alloc_idx[i] = '0;
            found        = 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (!found && avail[s]) begin
                    found        = 1'b1;
                    alloc_idx[i] = IDX_W'(s);
                end
            end
            if (found) begin
                avail[alloc_idx[i]] = 1'b0;
            end
        end
    end

`ifdef DSQ_BYPASS_EN
    assign bypass_on = (count_q == '0) && !bus.flush;
`else
    assign bypass_on = 1'b0;
`endif

    for (genvar gi = 0; gi < SEL_WIDTH; gi++) begin : g_sel
        logic [PTR_W-1:0] rd_ptr;
        logic             q_valid;
        assign rd_ptr  = head_q + PTR_W'(gi);
        assign q_valid = (count_q > CNT_W'(gi)) && !bus.flush;
`ifdef DSQ_BYPASS_EN
        if (gi < DISP_WIDTH) begin : g_byp
            assign sel_valid[gi] = bypass_on ? accept[gi] : q_valid;
            assign bus.sel_uop[gi*UOP_W +: UOP_W] =
                bypass_on ? bus.disp_uop[gi*UOP_W +: UOP_W] : uop_mem_q[rd_ptr];
            assign bus.sel_idx[gi*IDX_W +: IDX_W] =
                bypass_on ? alloc_idx[gi] : idx_mem_q[rd_ptr];
        end else begin : g_q
            assign sel_valid[gi] = q_valid;
            assign bus.sel_uop[gi*UOP_W +: UOP_W] = uop_mem_q[rd_ptr];
            assign bus.sel_idx[gi*IDX_W +: IDX_W] = idx_mem_q[rd_ptr];
        end
`else
        assign sel_valid[gi] = q_valid;
        assign bus.sel_uop[gi*UOP_W +: UOP_W] = uop_mem_q[rd_ptr];
        assign bus.sel_idx[gi*IDX_W +: IDX_W] = idx_mem_q[rd_ptr];
`endif
    end

    always_comb begin
        logic run;
        run     = 1'b1;
        pop_cnt = '0;
        for (int k = 0; k < SEL_WIDTH; k++) begin
            run     = run & sel_valid[k] & bus.sel_ready[k];
            pop_cnt = pop_cnt + CNT_W'(run);
        end
    end

    // Bypassed lanes that were popped never touch the queue storage.
    assign skip_cnt = bypass_on ? pop_cnt : '0;

    always_comb begin
        for (int i = 0; i < DISP_WIDTH; i++) begin
            wr_addr[i] = tail_q + PTR_W'(i) - PTR_W'(skip_cnt);
        end
    end

    always_comb begin
        logic [PTR_W-1:0] off;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        slot_free_d = slot_free_q;
        off         = '0;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            for (int e = 0; e < DEPTH; e++) begin
                off = PTR_W'(e) - head_q;
                if ({1'b0, off} < count_q) begin
                    slot_free_d[idx_mem_q[e]] = 1'b1;
                end
            end
        end else begin
            head_d  = head_q + PTR_W'(pop_cnt - skip_cnt);
            tail_d  = tail_q + PTR_W'(enq_cnt - skip_cnt);
            count_d = count_q + enq_cnt - pop_cnt;
        end
        for (int j = 0; j < SEL_WIDTH; j++) begin
            if (bus.free_valid[j]) begin
                slot_free_d[bus.free_idx[j*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        for (int i = 0; i < DISP_WIDTH; i++) begin
            if (accept[i]) begin
                slot_free_d[alloc_idx[i]] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            slot_free_q <= '1;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            slot_free_q <= slot_free_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DISP_WIDTH; i++) begin
            if (accept[i] && (CNT_W'(i) >= skip_cnt)) begin
                uop_mem_q[wr_addr[i]] <= bus.disp_uop[i*UOP_W +: UOP_W];
                idx_mem_q[wr_addr[i]] <= alloc_idx[i];
            end
        end
    end

    assign bus.disp_ready = disp_ready;
    assign bus.sel_valid  = sel_valid;
    assign bus.count      = count_q;
    assign bus.free_slots = free_cnt;
endmodule

// File: doc/dispatch_select_queue.md
Name: dispatch_select_queue

Overview:
- Multi-lane decoupling queue between Dispatch and Select; parametrised successor to the single-lane Dispatch→Select handoff.
- Accepts up to DISP_WIDTH uops per cycle and allocates a payload-RAM slot index to each at enqueue.
- Presents up to SEL_WIDTH oldest entries per cycle to Select, in order.
- Recycles slot indices returned by downstream; supports pipeline flush.

Parameters:
DISP_WIDTH, 2, dispatch lanes per cycle
SEL_WIDTH, 2, select lanes per cycle; also the number of slot-free return ports
DEPTH, 8, queue entries; power of two, >= DISP_WIDTH
UOP_W, 64, width of one flattened DispUOP
NUM_SLOTS, 16, payload-RAM slots; power of two, >= DISP_WIDTH; IDX_W = $clog2(NUM_SLOTS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all queued entries
disp_valid  in  DISP_WIDTH  per-lane dispatch valid, packed from lane 0
disp_uop  in  DISP_WIDTH*UOP_W  dispatch uops; lane i at [i*UOP_W +: UOP_W]
disp_ready  out  1  group accept, all-or-nothing
sel_valid  out  SEL_WIDTH  per-lane entry valid
sel_uop  out  SEL_WIDTH*UOP_W  oldest entries; lane 0 = oldest
sel_idx  out  SEL_WIDTH*IDX_W  slot index bound to each entry
sel_ready  in  SEL_WIDTH  per-lane pop request
free_valid  in  SEL_WIDTH  slot-return strobes
free_idx  in  SEL_WIDTH*IDX_W  slot indices being returned
count  out  $clog2(DEPTH+1)  occupied entries
free_slots  out  $clog2(NUM_SLOTS+1)  unallocated slots

Behaviour:
- Reset (async assert, clocked deassert): head=0, tail=0, count=0, slot bitmap all free.
  - Outputs at reset: sel_valid=0, free_slots=NUM_SLOTS, disp_ready=1.
- disp_ready is combinational on registered state only:
  - 1 iff (DEPTH-count >= DISP_WIDTH) && (free_slots >= DISP_WIDTH) && !flush.
  - Same-cycle pops and frees do not raise it.
- Enqueue:
  - Lane i is accepted iff disp_ready && disp_valid[0..i] are all 1.
  - Non-contiguous valid: only the prefix is accepted; the rest are dropped. This is an illegal input.
- Slot allocation: the k-th accepted lane receives the k-th lowest-numbered free slot.
  - Bitmap clears at the edge; index stored with the uop.
- Latency: an entry enqueued at edge N is visible on sel_* from cycle N+1. No bypass (see Optional Feature).
- Select lanes:
  - sel_valid[k] = (count > k) && !flush.
  - sel_uop/sel_idx[k] = entry at head+k (mod DEPTH).
  - Lane k pops iff sel_valid[0..k] && sel_ready[0..k] are all 1 (in-order prefix).
  - Popped slots stay allocated until returned on free_*.
- Pointers wrap modulo DEPTH; count += enq - pop each cycle, including full→empty and empty→full in one cycle.
- Free ports:
  - Each free_valid[j] sets bitmap[free_idx[j]] at the edge.
  - Duplicate indices in one cycle, or an index that is already free: idempotent, no error.
  - A freed slot is allocatable in the next cycle, not the same one.
- Flush:
  - Cycle behaviour: disp_ready=0, sel_valid=0, no enqueue, no pop.
  - At the edge: head=tail=0, count=0, and the slots of all queued entries are returned to the bitmap.
  - free_* still applies in a flush cycle.
  - Slots already popped are not reclaimed by flush.
- Reset mid-operation: immediate return to the reset state; all slots free.

Optional Feature:
DSQ_BYPASS_EN
- Defined:
  - When count==0 and !flush, accepted dispatch lanes also drive sel_* combinationally in the same cycle, with their newly allocated indices.
  - Lanes popped that cycle are not written to the queue; unpopped lanes are enqueued normally.
  - Requires SEL_WIDTH >= DISP_WIDTH for full bypass; excess lanes are enqueued.
- Undefined: 1-cycle minimum latency as above; no combinational path from disp_* to sel_*.

Test Plan:
- Reset, then 4 cycles of 2-lane dispatch (uops 0xA0..0xA7), sel_ready=0 → count 8, disp_ready=0, slots 0..7 allocated in order, sel_uop lane0=0xA0 with idx 0, lane1=0xA1 with idx 1.
- Full queue with sel_ready=2'b01 and dispatch held → one pop per cycle; disp_ready rises when count=6; head wraps correctly past entry 7.
- sel_ready=2'b10 with 2 valid entries → no pop (prefix rule); count unchanged.
- Allocate 16 slots with no frees → disp_ready=0 even with queue space; free_idx 3 and 9 → next cycle disp_ready=1, next dispatch receives idx 3 and 9.
- Flush with 5 entries (slots 0..4) queued while free_idx=7 is returned → count 0, free_slots increases by 6, sel_valid=0 during the flush cycle.
- DSQ_BYPASS_EN, empty queue, 2-lane dispatch with sel_ready=2'b11 → sel_valid=2'b11 in the same cycle, count remains 0, slots 0 and 1 remain allocated.
